// File: rtl/seq_mult_pkg.sv
// Shared types and width helpers for the shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Step counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
    function automatic int count_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/seq_mult_sign_fix.sv
// Magnitude/sign capture and final negation for two's complement operation.
// Only built when SEQ_MULT_SIGNED_EN is defined.
`ifdef SEQ_MULT_SIGNED_EN
module seq_mult_sign_fix #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] acc,
    input  logic               neg,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               sign,
    output logic [2*WIDTH-1:0] p_fixed
);

    // The most-negative value negates to itself, which read unsigned is its magnitude.
    assign a_mag   = a[WIDTH-1] ? -a : a;
    assign b_mag   = b[WIDTH-1] ? -b : b;
    assign sign    = a[WIDTH-1] ^ b[WIDTH-1];
    assign p_fixed = neg ? -acc : acc;

endmodule
`endif

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// Define SEQ_MULT_SIGNED_EN for two's complement operands.
module seq_shift_add_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p,
    output logic               state_dbg
);

    localparam int PW = prod_width(WIDTH);
    localparam int CW = count_width(WIDTH);

    // Handshake: start is taken only in IDLE (busy=0), operands are captured on
    // that edge; busy stays high for WIDTH cycles, then done pulses for one cycle
    // with p valid. p holds until the next done.

    state_t          state, state_d;
    logic [PW-1:0]   acc, acc_d, mcand, mcand_d, p_d, acc_sum, p_res;
    logic [WIDTH-1:0] mplier, mplier_d, a_mag, b_mag;
    logic [CW-1:0]   count, count_d;
    logic            busy_d, done_d, last_step;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d, sign_in;

    seq_mult_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a       (a),
        .b       (b),
        .acc     (acc_sum),
        .neg     (neg_q),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .sign    (sign_in),
        .p_fixed (p_res)
    );
`else
    assign a_mag = a;
    assign b_mag = b;
    assign p_res = acc_sum;
`endif

    assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
    assign last_step = (count == CW'(WIDTH - 1));
    assign state_dbg = (state == RUN);

    always_comb begin
        state_d  = state;
        acc_d    = acc;
        mcand_d  = mcand;
        mplier_d = mplier;
        count_d  = count;
        busy_d   = busy;
        done_d   = 1'b0;
        p_d      = p;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    count_d  = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d    = sign_in;
`endif
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand << 1;
                mplier_d = mplier >> 1;
                count_d  = count + CW'(1);
                if (last_step) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    p_d     = p_res;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q  <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            acc    <= acc_d;
            mcand  <= mcand_d;
            mplier <= mplier_d;
            count  <= count_d;
            busy   <= busy_d;
            done   <= done_d;
            p      <= p_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q  <= neg_d;
`endif
        end
    end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised, iterative (shift-add) unsigned multiplier; successor to the 4x4 combinational array multiplier.
- Operand width is generic. Processes one multiplier bit per clock, so area grows linearly rather than quadratically.
- Uses a start/busy/done handshake and holds the result registered until the next operation.
- Sits between the tile I/O wrapper (ui_in/uio_in operand capture) and the uo_out result mux.

Parameters:
- WIDTH, 4, operand width in bits (legal 2..16); product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, captured on accepted start
- b  input  WIDTH  multiplier, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when p becomes valid
- p  output  2*WIDTH  product, registered, held until next completion

Behaviour:
- Reset: one clock; reset asynchronous active-low. While rst_n=0: state=IDLE, busy=0, done=0, p=0, internal acc/mcand/mplier/count=0.
- Deassertion is synchronised by the wrapper; the block samples start from the first edge after release.
- States:
  - IDLE: start=1 at edge t0 -> RUN. Capture mcand={WIDTH'0,a}, mplier=b, acc=0, count=0.
  - RUN: on each edge, if mplier[0] then acc=acc+mcand (2*WIDTH bits, no overflow possible); then mcand<<=1, mplier>>=1, count++.
  - RUN exit: when count==WIDTH-1 at an edge, that edge performs the final step, writes p=final acc, sets done=1 and returns to IDLE.
- Latency: start sampled at edge t0 -> p valid and done=1 after edge t0+WIDTH.
- Throughput: fixed, one result per WIDTH+1 cycles. There is no early termination on zero operands.
- busy: registered; 1 after t0 through edge t0+WIDTH, 0 in the done cycle.
- done: exactly one cycle; cleared on the next edge regardless of start.
- start while busy: ignored; a/b changes during RUN have no effect.
- start in the done cycle (state IDLE): accepted; back-to-back operation allowed, done and new busy coincide for zero cycles (busy rises at the edge done falls).
- start held high continuously: a new operation starts every WIDTH+1 cycles.
- p is unchanged from one done to the next; it is never partially updated.
- Reset mid-RUN: abort, outputs return to reset values immediately, and no done pulse is emitted.
- count width: $clog2(WIDTH); the counter never wraps within an operation.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined: a and b are two's complement.
  - At accept, capture |a| and |b| and sign flag s=a[MSB]^b[MSB].
  - At completion, p = s ? -acc : acc (2*WIDTH-bit two's complement).
  - Most-negative operands are handled: magnitude 2^(WIDTH-1) fits unsigned.
  - Latency unchanged: sign fix is combinational into the p register.
- Not defined: pure unsigned operation; no sign logic synthesised.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum (IDLE, RUN)
  - localparam helper for counter width
  - PW=2*WIDTH convention
- Sub-module seq_mult_sign_fix: abs/negate helpers. Instantiated only under SEQ_MULT_SIGNED_EN; otherwise everything stays in one module.

Test Plan:
- WIDTH=4, a=15, b=15, start pulse at t0 -> busy=1 for 4 cycles, done pulse after edge t0+4, p=8'd225. Also a=0, b=9 -> p=0, same latency.
- WIDTH=4 exhaustive 256 pairs back-to-back with start held high -> each done carries p=a*b; spacing of 5 cycles between dones.
- Change a/b and pulse start mid-RUN (a=3, b=5 then a=7, b=7 at t0+2) -> p=15 only, single done, no extra operation.
- Assert rst_n=0 at t0+2 of a 9*9 operation -> busy/done/p=0 asynchronously. After release, start 2*3 -> p=6, done once.
- WIDTH=8, a=255, b=255 -> p=16'd65025 after 8 cycles; p holds value across 20 idle cycles.
- SEQ_MULT_SIGNED_EN, WIDTH=4:
  - -3*5 -> p=8'hF1
  - -8*-8 -> p=8'd64
  - -8*7 -> p=8'hC8
